// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, control-bundle layout and memory FSM states for the pipelined control unit
package cu_pkg;
  localparam int CTRL_W      = 13;
  localparam int MEM_TO_REG  = 12;
  localparam int REG_WRITE   = 11;
  localparam int MEM_READ    = 10;
  localparam int MEM_WRITE   = 9;
  localparam int BRANCH      = 8;
  localparam int JUMP        = 7;
  localparam int BRANCH_FLIP = 6;
  localparam int ALU_OP_LO   = 4;
  localparam int REG_DST_LO  = 2;
  localparam int ALU_SRC_LO  = 0;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_LWI  = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_BLT  = 6'b000011;
  localparam logic [5:0] OP_BGE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_JR   = 6'b000111;
  localparam logic [5:0] OP_NOP  = 6'b111111;
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;
  typedef enum logic {MS_IDLE, MS_WAIT} mem_state_e;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode to control-bundle table
module cu_decode
  import cu_pkg::*;
(
  input  logic [5:0]        opcode,
  output logic [CTRL_W-1:0] ctrl
);
  always_comb begin
    ctrl = NOP_CTRL;
    case (opcode)
      OP_R:    ctrl = 13'b0100000_10_01_00;
      OP_ADDI: ctrl = 13'b0100000_00_00_01;
      OP_SUBI: ctrl = 13'b0100000_01_00_01;
      OP_LWI:  ctrl = 13'b0100000_00_00_01;
      OP_BEQ:  ctrl = 13'b0000100_01_00_00;
      OP_BNE:  ctrl = 13'b0000101_01_00_00;
      OP_BLT:  ctrl = 13'b0000101_11_00_00;
      OP_BGE:  ctrl = 13'b0000100_11_00_00;
      OP_J:    ctrl = 13'b0000010_00_00_00;
      OP_LW:   ctrl = 13'b1110000_00_00_01;
      OP_SW:   ctrl = 13'b0001000_00_00_01;
      OP_JAL:  ctrl = 13'b0100010_11_10_10;
      OP_JR:   ctrl = 13'b0000010_11_00_00;
      default: ctrl = NOP_CTRL;
    endcase
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID decode into the ID/EX register with load-use stall,
// flush bubbles and a data-memory wait FSM with timeout
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LINK_REG    = 31,
  parameter int HAZARD_EN   = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              stall_id,
  output logic              mem_req,
  output logic              mem_err,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CTRL_W-1:0] dec;
  logic [1:0]        dec_rdst;
  logic [REG_AW-1:0] dec_dest;
  logic              hazard, mem_stall, timeout_hit, bubble;
  mem_state_e        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  cu_decode u_decode (.opcode(opcode), .ctrl(dec));
  assign dec_rdst    = dec[REG_DST_LO +: 2];
  assign dec_dest    = dec_rdst == 2'b10 ? REG_AW'(LINK_REG) : dec_rdst == 2'b01 ? rd : rt;
  assign hazard      = (HAZARD_EN != 0) & id_valid & ex_valid & ex_ctrl[MEM_READ] & (ex_dest == rs | ex_dest == rt);
  assign mem_req     = ex_valid & (ex_ctrl[MEM_READ] | ex_ctrl[MEM_WRITE]);
  assign timeout_hit = state == MS_WAIT && !mem_ready && cnt == CW'(MEM_TIMEOUT);
  assign mem_stall   = mem_req & ~mem_ready & ~timeout_hit;
  assign stall_id    = hazard | mem_stall;
  // a timed-out load/store is dropped along with whatever sits in ID this cycle
  assign bubble      = timeout_hit | flush | hazard | ~id_valid;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == MS_IDLE) begin
      if (mem_req && !mem_ready) begin
        state_n = MS_WAIT;
        cnt_n   = CW'(1);
      end
    end else if (mem_ready || timeout_hit) begin
      state_n = MS_IDLE;
      cnt_n   = '0;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MS_IDLE;
      cnt      <= '0;
      mem_err  <= 1'b0;
      ex_valid <= 1'b0;
      ex_dest  <= '0;
      ex_ctrl  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      mem_err <= mem_err | timeout_hit;
      if (!mem_stall) begin
        ex_valid <= ~bubble;
        ex_dest  <= bubble ? '0 : dec_dest;
        ex_ctrl  <= bubble ? '0 : dec;
      end
    end
  end
endmodule
